// File: rtl/decimator_multimode.sv
// Block decimator: reduces each block of N valid samples to one output by
// last/max/min/mean, with ratio/mode/shift changes deferred to block boundaries.
module decimator_multimode #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned RATIO_BITS    = 14,
  parameter int unsigned DEFAULT_RATIO = 10000,
  parameter int unsigned SHIFT_BITS    = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [WIDTH-1:0]      iData,
  input  logic                  iData_Valid,
  input  logic [RATIO_BITS-1:0] iRatio,
  input  logic [1:0]            iMode,
  input  logic [SHIFT_BITS-1:0] iShift,
  input  logic                  iCfg_Load,
  input  logic                  iClear,
  output logic [WIDTH-1:0]      oData,
  output logic                  oData_Valid,
  output logic                  oCfg_Pending
);

  localparam int unsigned ACC_W = WIDTH + RATIO_BITS;

  logic [RATIO_BITS-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]      odata_q, odata_d;
  logic                  ovalid_q, ovalid_d;

  logic [RATIO_BITS-1:0] ratio_q, ratio_d;
  logic [1:0]            mode_q, mode_d;
  logic [SHIFT_BITS-1:0] shift_q, shift_d;

  logic                  pend_q, pend_d;
  logic [RATIO_BITS-1:0] pend_ratio_q, pend_ratio_d;
  logic [1:0]            pend_mode_q, pend_mode_d;
  logic [SHIFT_BITS-1:0] pend_shift_q, pend_shift_d;

  logic                  is_first;
  logic                  use_pend;
  logic                  is_final;
  logic [RATIO_BITS-1:0] sel_ratio;
  logic [RATIO_BITS-1:0] eff_ratio;
  logic [1:0]            sel_mode;
  logic [SHIFT_BITS-1:0] sel_shift;
  logic [ACC_W-1:0]      sample_ext;
  logic [ACC_W-1:0]      run_val;
  logic [ACC_W-1:0]      shifted;
  logic [WIDTH-1:0]      result;

  // With no block in progress a pending config already governs this cycle's sample.
  always_comb begin
    is_first   = (cnt_q == '0);
    use_pend   = pend_q && is_first;
    sel_ratio  = use_pend ? pend_ratio_q : ratio_q;
    sel_mode   = use_pend ? pend_mode_q  : mode_q;
    sel_shift  = use_pend ? pend_shift_q : shift_q;
    eff_ratio  = (sel_ratio == '0) ? RATIO_BITS'(1) : sel_ratio;
    is_final   = iData_Valid && (cnt_q == eff_ratio - RATIO_BITS'(1));
    sample_ext = ACC_W'(iData);

    case (sel_mode)
      2'd0:    run_val = sample_ext;
      2'd1:    run_val = (is_first || sample_ext > acc_q) ? sample_ext : acc_q;
      2'd2:    run_val = (is_first || sample_ext < acc_q) ? sample_ext : acc_q;
      default: run_val = is_first ? sample_ext : acc_q + sample_ext;
    endcase

    shifted = run_val >> sel_shift;
    if (sel_mode == 2'd3) begin
      result = (|shifted[ACC_W-1:WIDTH]) ? '1 : shifted[WIDTH-1:0];
    end else begin
      result = run_val[WIDTH-1:0];
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    odata_d      = odata_q;
    ovalid_d     = 1'b0;
    ratio_d      = ratio_q;
    mode_d       = mode_q;
    shift_d      = shift_q;
    pend_d       = pend_q;
    pend_ratio_d = pend_ratio_q;
    pend_mode_d  = pend_mode_q;
    pend_shift_d = pend_shift_q;

    if (iClear) begin
      cnt_d = '0;
      acc_d = '0;
      if (iCfg_Load) begin
        ratio_d = iRatio;
        mode_d  = iMode;
        shift_d = iShift;
        pend_d  = 1'b0;
      end else if (pend_q) begin
        ratio_d = pend_ratio_q;
        mode_d  = pend_mode_q;
        shift_d = pend_shift_q;
        pend_d  = 1'b0;
      end
    end else begin
      if (iData_Valid) begin
        if (is_final) begin
          ovalid_d = 1'b1;
          odata_d  = result;
          cnt_d    = '0;
          acc_d    = '0;
        end else begin
          cnt_d = cnt_q + RATIO_BITS'(1);
          acc_d = run_val;
        end
      end
      if (pend_q && (is_first || is_final)) begin
        ratio_d = pend_ratio_q;
        mode_d  = pend_mode_q;
        shift_d = pend_shift_q;
        pend_d  = 1'b0;
      end
      // A load in the final-sample cycle stays pending and takes over on the next cycle.
      if (iCfg_Load) begin
        pend_d       = 1'b1;
        pend_ratio_d = iRatio;
        pend_mode_d  = iMode;
        pend_shift_d = iShift;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      odata_q      <= '0;
      ovalid_q     <= 1'b0;
      ratio_q      <= RATIO_BITS'(DEFAULT_RATIO);
      mode_q       <= '0;
      shift_q      <= '0;
      pend_q       <= 1'b0;
      pend_ratio_q <= '0;
      pend_mode_q  <= '0;
      pend_shift_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      odata_q      <= odata_d;
      ovalid_q     <= ovalid_d;
      ratio_q      <= ratio_d;
      mode_q       <= mode_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      pend_ratio_q <= pend_ratio_d;
      pend_mode_q  <= pend_mode_d;
      pend_shift_q <= pend_shift_d;
    end
  end

  assign oData        = odata_q;
  assign oData_Valid  = ovalid_q;
  assign oCfg_Pending = pend_q;

endmodule

// File: tb/tb_decimator_multimode.sv
// Directed bench for decimator_multimode: block reductions, deferred config,
// valid gaps, ratio 0/1 pass-through, reset and clear aborts.
module tb_decimator_multimode;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic [7:0]  iData = '0;
  logic        iData_Valid = 1'b0;
  logic [13:0] iRatio = '0;
  logic [1:0]  iMode = '0;
  logic [3:0]  iShift = '0;
  logic        iCfg_Load = 1'b0;
  logic        iClear = 1'b0;
  logic [7:0]  oData;
  logic        oData_Valid;
  logic        oCfg_Pending;

  int total = 0;
  int passed = 0;
  int early = 0;

  decimator_multimode #(
    .WIDTH(8),
    .RATIO_BITS(14),
    .DEFAULT_RATIO(10000),
    .SHIFT_BITS(4)
  ) dut (
    .iClk(iClk),
    .iRst_n(iRst_n),
    .iData(iData),
    .iData_Valid(iData_Valid),
    .iRatio(iRatio),
    .iMode(iMode),
    .iShift(iShift),
    .iCfg_Load(iCfg_Load),
    .iClear(iClear),
    .oData(oData),
    .oData_Valid(oData_Valid),
    .oCfg_Pending(oCfg_Pending)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one cycle of input, then sample outputs 1 time unit after the edge.
  task automatic cyc(input logic [7:0] d, input logic v);
    iData = d;
    iData_Valid = v;
    @(posedge iClk);
    #1;
    iData_Valid = 1'b0;
    iCfg_Load = 1'b0;
    iClear = 1'b0;
  endtask

  task automatic load(input logic [13:0] r, input logic [1:0] m, input logic [3:0] s);
    iRatio = r;
    iMode = m;
    iShift = s;
    iCfg_Load = 1'b1;
    cyc(8'h00, 1'b0);
  endtask

  initial begin
    // reset
    #2;
    chk("rst_data", 32'(oData), 32'h0);
    chk("rst_valid", 32'(oData_Valid), 32'h0);
    chk("rst_pend", 32'(oCfg_Pending), 32'h0);
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;

    // 1: default ratio 10000, mode 0, ramp
    for (int i = 0; i < 10000; i++) begin
      cyc(8'(i), 1'b1);
      if (i < 9999 && oData_Valid) early++;
    end
    chk("t1_valid", 32'(oData_Valid), 32'h1);
    chk("t1_data", 32'(oData), 32'h0F);
    chk("t1_early", 32'(early), 32'h0);
    cyc(8'h00, 1'b0);
    chk("t1_pulse_end", 32'(oData_Valid), 32'h0);
    chk("t1_hold", 32'(oData), 32'h0F);

    // 2: max then min, ratio 4
    load(14'd4, 2'd1, 4'd0);
    chk("t2_pend", 32'(oCfg_Pending), 32'h1);
    cyc(8'd3, 1'b1); cyc(8'd9, 1'b1); cyc(8'd2, 1'b1);
    chk("t2_no_early", 32'(oData_Valid), 32'h0);
    cyc(8'd7, 1'b1);
    chk("t2_max_v", 32'(oData_Valid), 32'h1);
    chk("t2_max_d", 32'(oData), 32'd9);
    cyc(8'd1, 1'b1); cyc(8'd1, 1'b1); cyc(8'd1, 1'b1); cyc(8'd1, 1'b1);
    chk("t2_max2_v", 32'(oData_Valid), 32'h1);
    chk("t2_max2_d", 32'(oData), 32'd1);
    load(14'd4, 2'd2, 4'd0);
    cyc(8'd3, 1'b1); cyc(8'd9, 1'b1); cyc(8'd2, 1'b1); cyc(8'd7, 1'b1);
    chk("t2_min_v", 32'(oData_Valid), 32'h1);
    chk("t2_min_d", 32'(oData), 32'd2);

    // 3: mean and saturation
    load(14'd4, 2'd3, 4'd2);
    cyc(8'd10, 1'b1); cyc(8'd20, 1'b1); cyc(8'd30, 1'b1); cyc(8'd41, 1'b1);
    chk("t3_mean_v", 32'(oData_Valid), 32'h1);
    chk("t3_mean_d", 32'(oData), 32'd25);
    load(14'd4, 2'd3, 4'd1);
    cyc(8'd255, 1'b1); cyc(8'd255, 1'b1); cyc(8'd255, 1'b1); cyc(8'd255, 1'b1);
    chk("t3_sat_v", 32'(oData_Valid), 32'h1);
    chk("t3_sat_d", 32'(oData), 32'd255);

    // 4: ratio change mid-block waits for the boundary
    load(14'd4, 2'd0, 4'd0);
    cyc(8'd1, 1'b1); cyc(8'd2, 1'b1);
    load(14'd2, 2'd0, 4'd0);
    chk("t4_pend_hi", 32'(oCfg_Pending), 32'h1);
    cyc(8'd3, 1'b1);
    chk("t4_no_out3", 32'(oData_Valid), 32'h0);
    chk("t4_pend_hi2", 32'(oCfg_Pending), 32'h1);
    cyc(8'd4, 1'b1);
    chk("t4_old_v", 32'(oData_Valid), 32'h1);
    chk("t4_old_d", 32'(oData), 32'd4);
    chk("t4_pend_lo", 32'(oCfg_Pending), 32'h0);
    cyc(8'd5, 1'b1);
    chk("t4_new_gap", 32'(oData_Valid), 32'h0);
    cyc(8'd6, 1'b1);
    chk("t4_new_v", 32'(oData_Valid), 32'h1);
    chk("t4_new_d", 32'(oData), 32'd6);
    cyc(8'd7, 1'b1); cyc(8'd8, 1'b1);
    chk("t4_new2_d", 32'(oData), 32'd8);

    // 5: gaps in valid, ratio 3 max; then ratio 0 pass-through
    load(14'd3, 2'd1, 4'd0);
    cyc(8'd5, 1'b1); cyc(8'd0, 1'b0);
    chk("t5_gap1", 32'(oData_Valid), 32'h0);
    cyc(8'd9, 1'b1); cyc(8'd0, 1'b0);
    chk("t5_gap2", 32'(oData_Valid), 32'h0);
    cyc(8'd4, 1'b1);
    chk("t5_v", 32'(oData_Valid), 32'h1);
    chk("t5_d", 32'(oData), 32'd9);
    load(14'd0, 2'd0, 4'd0);
    cyc(8'h11, 1'b1);
    chk("t5_r0a_v", 32'(oData_Valid), 32'h1);
    chk("t5_r0a_d", 32'(oData), 32'h11);
    cyc(8'h00, 1'b0);
    chk("t5_r0_idle", 32'(oData_Valid), 32'h0);
    cyc(8'h22, 1'b1);
    chk("t5_r0b_d", 32'(oData), 32'h22);
    load(14'd0, 2'd3, 4'd0);
    cyc(8'hAB, 1'b1);
    chk("t5_mean1_v", 32'(oData_Valid), 32'h1);
    chk("t5_mean1_d", 32'(oData), 32'hAB);

    // 6a: async reset mid-block discards the partial block
    load(14'd4, 2'd1, 4'd0);
    cyc(8'd50, 1'b1); cyc(8'd60, 1'b1);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("t6_rst_data", 32'(oData), 32'h0);
    chk("t6_rst_pend", 32'(oCfg_Pending), 32'h0);
    @(posedge iClk);
    #1;
    chk("t6_rst_valid", 32'(oData_Valid), 32'h0);
    iRst_n = 1'b1;
    load(14'd4, 2'd1, 4'd0);
    cyc(8'd1, 1'b1); cyc(8'd2, 1'b1);
    chk("t6_rst_noout", 32'(oData_Valid), 32'h0);
    cyc(8'd3, 1'b1); cyc(8'd4, 1'b1);
    chk("t6_rst_v", 32'(oData_Valid), 32'h1);
    chk("t6_rst_d", 32'(oData), 32'd4);

    // 6b: clear coincident with the final sample
    cyc(8'd10, 1'b1); cyc(8'd20, 1'b1); cyc(8'd30, 1'b1);
    iClear = 1'b1;
    cyc(8'd40, 1'b1);
    chk("t6_clr_noout", 32'(oData_Valid), 32'h0);
    cyc(8'd5, 1'b1); cyc(8'd6, 1'b1); cyc(8'd7, 1'b1); cyc(8'd8, 1'b1);
    chk("t6_clr_v", 32'(oData_Valid), 32'h1);
    chk("t6_clr_d", 32'(oData), 32'd8);

    // 6c: clear with load activates the config at once
    cyc(8'd1, 1'b1); cyc(8'd2, 1'b1);
    iRatio = 14'd2;
    iMode = 2'd2;
    iShift = 4'd0;
    iCfg_Load = 1'b1;
    iClear = 1'b1;
    cyc(8'd0, 1'b0);
    chk("t6_cl_pend", 32'(oCfg_Pending), 32'h0);
    chk("t6_cl_noout", 32'(oData_Valid), 32'h0);
    cyc(8'd9, 1'b1); cyc(8'd3, 1'b1);
    chk("t6_cl_v", 32'(oData_Valid), 32'h1);
    chk("t6_cl_d", 32'(oData), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
